// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: resolves mem waits, EX redirects
// and load-use hazards with fixed priority and counts stalled PC cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] id_rs_addr,
  input  logic [REG_ADDR_LEN-1:0] id_rt_addr,
  input  logic                    id_uses_rs,
  input  logic                    id_uses_rt,
  input  logic                    ex_mem_read,
  input  logic [REG_ADDR_LEN-1:0] ex_rt_addr,
  input  logic                    ex_branch_taken,
  input  logic                    ex_jump,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  output logic                    pc_stall,
  output logic                    if_id_stall,
  output logic                    if_id_flush,
  output logic                    id_ex_stall,
  output logic                    id_ex_flush,
  output logic                    ex_mem_stall,
  output logic                    mem_wb_bubble,
  output logic [1:0]              hazard_state,
  output logic [CNT_WIDTH-1:0]    stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_ONE    = FC_W'(1);

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic            mem_wait, redirect, load_use;
  logic            run_rules, mem_term;

  assign mem_wait = mem_req & ~mem_ready;
  assign redirect = ex_branch_taken | ex_jump;
  assign load_use = ex_mem_read & (ex_rt_addr != '0) &
                    ((id_uses_rs & (id_rs_addr == ex_rt_addr)) |
                     (id_uses_rt & (id_rt_addr == ex_rt_addr)));

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    run_rules     = 1'b0;
    mem_term      = 1'b0;

    case (state)
      RUN: begin
        run_rules = 1'b1;
        mem_term  = mem_wait;
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          mem_wb_bubble = 1'b1;
        end else begin
          run_rules = 1'b1;
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        // ID/EX is being squashed anyway, so it gets the flush rather than a hold.
        if (mem_wait) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          mem_wb_bubble = 1'b1;
        end else begin
          flush_cnt_nxt = flush_cnt - FC_ONE;
          if (flush_cnt <= FC_ONE) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (run_rules) begin
      if (mem_term) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
        state_nxt     = MEM_WAIT;
      end else if (redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FC_RELOAD;
        end
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      flush_cnt   <= '0;
      stall_count <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (pc_stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

  assign hazard_state = state;

endmodule
